// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin registered multiplexer slice.
// Optional feature macro: RR_MUX_PARITY_EN (see rr_mux_pipe).
package rr_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: rotating-priority search starting at the pointer it owns.
// The pointer moves one past the winner whenever the caller reports a load.
module rr_arb
    import rr_mux_pkg::*;
#(
    parameter int unsigned NCH = 8,
    parameter int unsigned SW  = chan_idx_w(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           adv,
    output logic [SW-1:0]  ptr,
    output logic [SW-1:0]  gnt,
    output logic           gnt_vld
);

    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_gnt;
    logic [SW-1:0] w_idx;

    // Scan from the farthest offset down so the offset nearest ptr wins;
    // index arithmetic wraps naturally because NCH is a power of two.
    always_comb begin
        w_gnt = r_ptr;
        w_idx = r_ptr;
        for (int unsigned k = 0; k < NCH; k++) begin
            w_idx = r_ptr + SW'(NCH - 1 - k);
            if (req[w_idx]) begin
                w_gnt = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= w_gnt + SW'(1);
        end
    end

    assign ptr     = r_ptr;
    assign gnt     = w_gnt;
    assign gnt_vld = |req;

endmodule

// File: rtl/rr_mux_pipe.sv
// N-channel valid/ready multiplexer with fixed or round-robin selection and one output register.
// Optional `define RR_MUX_PARITY_EN adds registered out_par = ^out_data.
module rr_mux_pipe
    import rr_mux_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned NCH = 8,
    parameter int unsigned SW  = chan_idx_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [NCH*W-1:0] in_data,
    input  logic [NCH-1:0]   in_valid,
    output logic [NCH-1:0]   in_ready,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    output logic             out_valid,
`ifdef RR_MUX_PARITY_EN
    output logic             out_par,
`endif
    input  logic             out_ready
);

    logic [W-1:0]   r_out_data;
    logic [SW-1:0]  r_out_ch;
    logic           r_out_valid;

    logic           w_rr;
    logic [SW-1:0]  w_arb_ptr;
    logic [SW-1:0]  w_arb_gnt;
    logic           w_arb_vld;
    logic [SW-1:0]  w_gnt;
    logic           w_gnt_vld;
    logic           w_load;
    logic           w_adv;
    logic [W-1:0]   w_sel_data;
    logic [NCH-1:0] w_in_ready;

    assign w_rr = (mode_e'(mode) == MODE_RR);

    rr_arb #(
        .NCH (NCH),
        .SW  (SW)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .adv     (w_adv),
        .ptr     (w_arb_ptr),
        .gnt     (w_arb_gnt),
        .gnt_vld (w_arb_vld)
    );

    // FIXED mode bypasses the arbiter entirely and leaves its pointer untouched.
    always_comb begin
        w_gnt     = sel;
        w_gnt_vld = in_valid[sel];
        if (w_rr) begin
            w_gnt     = w_arb_gnt;
            w_gnt_vld = w_arb_vld;
        end
    end

    assign w_load     = (!r_out_valid || out_ready) && w_gnt_vld;
    assign w_adv      = w_load && w_rr;
    assign w_sel_data = in_data[w_gnt*W +: W];

    // Reset gates ready so no source sees a transfer while the stage is being cleared.
    always_comb begin
        w_in_ready = '0;
        if (w_load && !rst) begin
            w_in_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_gnt;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef RR_MUX_PARITY_EN
    logic r_out_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_par <= 1'b0;
        end else if (w_load) begin
            r_out_par <= ^w_sel_data;
        end
    end

    assign out_par = r_out_par;
`endif

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
